// File: rtl/mult_share_arbiter_pkg.sv
// Shared constants and helpers for the multiplier-sharing arbiter cluster.
package mult_pkg;
    localparam int OPERAND_W   = 8;
    localparam int PRODUCT_W   = 16;
    localparam int MAX_NUM_REQ = 16;

    // Width of a tag able to index `value` requesters; never narrower than one bit.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return (res < 1) ? 1 : res;
    endfunction
endpackage

// File: rtl/mult_share_arbiter_if.sv
// Request/response bundle between the requesters (master) and the shared multiplier (slave).
interface mult_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = mult_pkg::clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]                       req_valid;
    logic [NUM_REQ*mult_pkg::OPERAND_W-1:0]   req_a;
    logic [NUM_REQ*mult_pkg::OPERAND_W-1:0]   req_b;
    logic [NUM_REQ-1:0]                       req_ready;
    logic                                     rsp_valid;
    logic [ID_W-1:0]                          rsp_id;
    logic [mult_pkg::PRODUCT_W-1:0]           rsp_p;
    logic                                     busy;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, rsp_valid, rsp_id, rsp_p, busy
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, rsp_valid, rsp_id, rsp_p, busy
    );
endinterface

// File: rtl/mult_share_arbiter_pipe.sv
// Fixed-latency registered 8x8 multiplier carrying a valid bit and requester tag per stage.
module mult_pipe
    import mult_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    input  logic [OPERAND_W-1:0] a_i,
    input  logic [OPERAND_W-1:0] b_i,
    input  logic [ID_W-1:0]      id_i,
    output logic                 valid_o,
    output logic [ID_W-1:0]      id_o,
    output logic [PRODUCT_W-1:0] p_o,
    output logic                 busy_o
);
    logic [LATENCY-1:0]   valid_q;
    logic [PRODUCT_W-1:0] prod_q [LATENCY];
    logic [ID_W-1:0]      id_q   [LATENCY];
    logic [PRODUCT_W-1:0] prod_d;

    assign prod_d = PRODUCT_W'(a_i) * PRODUCT_W'(b_i);

    // Data only advances behind a valid bit, so the last stage holds the most recent result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                prod_q[s] <= '0;
                id_q[s]   <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            if (in_valid_i) begin
                prod_q[0] <= prod_d;
                id_q[0]   <= id_i;
            end
            for (int s = 1; s < LATENCY; s++) begin
                valid_q[s] <= valid_q[s-1];
                if (valid_q[s-1]) begin
                    prod_q[s] <= prod_q[s-1];
                    id_q[s]   <= id_q[s-1];
                end
            end
        end
    end

    assign valid_o = valid_q[LATENCY-1];
    assign id_o    = id_q[LATENCY-1];
    assign p_o     = prod_q[LATENCY-1];
    assign busy_o  = |valid_q;
endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters access to one pipelined multiplier.
module mult_share_arbiter
    import mult_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_share_arbiter_if.slave bus
);
    localparam int ID_W = clog2(NUM_REQ);

    logic [ID_W-1:0]      rr_ptr_q;
    logic [ID_W-1:0]      rr_ptr_d;
    logic [ID_W-1:0]      grant_id;
    logic [NUM_REQ-1:0]   grant;
    logic                 found;
    logic                 accept;
    logic [OPERAND_W-1:0] sel_a;
    logic [OPERAND_W-1:0] sel_b;
    logic                 pipe_valid;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
                found    = 1'b1;
                grant_id = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            end
        end
        if (found) grant[grant_id] = 1'b1;
    end

    assign accept        = found & rst_n;
    assign bus.req_ready = rst_n ? grant : '0;
    assign sel_a         = bus.req_a[int'(grant_id)*OPERAND_W +: OPERAND_W];
    assign sel_b         = bus.req_b[int'(grant_id)*OPERAND_W +: OPERAND_W];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    mult_pipe #(
        .LATENCY (LATENCY),
        .ID_W    (ID_W)
    ) u_pipe (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (accept),
        .a_i        (sel_a),
        .b_i        (sel_b),
        .id_i       (grant_id),
        .valid_o    (pipe_valid),
        .id_o       (bus.rsp_id),
        .p_o        (bus.rsp_p),
        .busy_o     (bus.busy)
    );

    // Suppress a result retiring in the very cycle reset is asserted; it belongs to discarded work.
    assign bus.rsp_valid = pipe_valid & rst_n;
endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Shares one pipelined 8x8 -> 16-bit unsigned multiplier between NUM_REQ independent requesters.
- Uses round-robin arbitration and a valid/ready request handshake.
- Returns each product tagged with the requester index, exactly LATENCY cycles after acceptance.
- Sits between multiple stochastic/probabilistic compute units and a single multiplier resource, so multiplier count stays at one per cluster.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- LATENCY, 2, multiplier pipeline depth in cycles from acceptance to result; legal range 1..4.
- ID_W, derived localparam clog2(NUM_REQ), width of the requester tag.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_a  in  NUM_REQ*8  operand A, packed; requester i occupies bits [8i+7:8i].
- req_b  in  NUM_REQ*8  operand B, packed the same way.
- req_ready  out  NUM_REQ  per-requester grant/accept; at most one bit high.
- rsp_valid  out  1  product valid, single-cycle pulse per accepted request.
- rsp_id  out  ID_W  index of the requester that owns rsp_p.
- rsp_p  out  16  unsigned product a*b.
- busy  out  1  high while any pipeline stage holds a valid operation.

Behaviour:
- Reset: while rst_n=0 at a rising edge, the following are cleared:
  - rr_ptr=0;
  - all pipeline valid bits=0;
  - rsp_valid=0, rsp_id=0, rsp_p=0, busy=0.
- Reset mid-operation: in-flight operations are discarded; no rsp_valid is produced for them.
- req_ready is combinational from req_valid and rr_ptr. It is forced to 0 during reset (rst_n=0).
- Arbitration, every cycle:
  - Search from rr_ptr upward, modulo NUM_REQ, for the first i with req_valid[i]=1.
  - Set req_ready[i]=1; all other req_ready bits are 0.
  - If no requester is valid, req_ready=0 and rr_ptr is unchanged.
- Transfer occurs when req_valid[i] & req_ready[i] at a rising edge.
  - On transfer, rr_ptr <= (i+1) mod NUM_REQ.
  - Operands and tag i are captured into pipeline stage 1.
- Throughput: one accepted request per cycle, sustained. The multiplier never stalls and the responder has no back-pressure.
- Latency: a request accepted at edge T produces rsp_valid=1 in the cycle following edge T+LATENCY-1, i.e. exactly LATENCY cycles after the accept cycle.
  - With LATENCY=1, the result appears in the cycle immediately after acceptance.
- rsp_valid is high for exactly one cycle per accepted request.
  - When rsp_valid=0, rsp_id and rsp_p hold their last values.
- Arithmetic: unsigned; product width 16 bits, no truncation. Example: 255*255=65025 (0xFE01).
- Requester contract: operands must be held stable while req_valid=1 and req_ready=0. The block does not check this.
- req_valid may drop without a transfer; no penalty, rr_ptr is unchanged.
- busy = OR of all pipeline-stage valid bits. It does not include the current-cycle request.
- Simultaneous events: a new accept and a retiring result in the same cycle are both handled; the pipeline shifts every cycle.
- Starvation bound: a continuously valid requester is granted within NUM_REQ cycles.

Decomposition:
- Shared package mult_pkg:
  - OPERAND_W=8, PRODUCT_W=16;
  - MAX_NUM_REQ=16;
  - function clog2 used for ID_W.
- One sub-module, mult_pipe: registered 8x8 multiplier with LATENCY stages.
  - Carries a valid bit and an ID_W tag alongside the product.
  - No handshake inside it.
- Arbiter and rr_ptr logic stay in the top module.

Test Plan:
- Reset, then single request: req_valid=0b0001, a=12, b=13.
  - req_ready=0b0001 in the same cycle.
  - rsp_valid pulses 2 cycles later with rsp_id=0, rsp_p=156.
  - busy high for exactly 2 cycles.
- All four requesters valid continuously for 8 cycles from reset.
  - Grants in order 0,1,2,3,0,1,2,3.
  - rsp_id follows the same sequence delayed by 2 cycles, one response per cycle.
- Corner values:
  - 255*255 gives rsp_p=65025.
  - 0*200 gives 0.
  - 1*255 gives 255.
- Pointer wrap and skip: rr_ptr=3 after a grant to 2, then only req 1 valid.
  - Grant goes to 1; rr_ptr becomes 2.
  - Next cycle reqs 0 and 3 valid: grant goes to 3.
- Reset mid-flight: accept requests in 2 consecutive cycles, then rst_n=0 for 1 cycle.
  - No rsp_valid ever appears for either request.
  - busy=0 after reset.
  - rsp_p=0.
- Random back-to-back traffic for 10k cycles, LATENCY=1 and LATENCY=4 builds.
  - Scoreboard requires every accepted (id,a,b) to return exactly once with p=a*b after exactly LATENCY cycles.
  - No grant gap exceeds NUM_REQ cycles for a continuously valid requester.
